// File: rtl/delay_pipe_pkg.sv
// Definitions shared between the static delay pipe and its egress buffer:
// wrap-increment pointer helper and the protocol-error cause encoding.
package delay_pipe_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ISSUE    = 2'd1,
    ERR_OVERFLOW = 2'd2
  } err_cause_e;

  // Pointer increment that wraps after 'limit', so depths need not be powers of 2.
  function automatic logic [31:0] ptr_wrap_inc(input logic [31:0] ptr, input logic [31:0] limit);
    return (ptr >= limit) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/delay_pipe_egress_buffer_if.sv
// Producer/consumer-facing signals of the egress buffer.
interface delay_pipe_egress_buffer_if #(
  parameter int D = 4,
  parameter int W = 32
);
  localparam int CW = $clog2(D + 1);

  logic          issue_vld;
  logic          issue_ok;
  logic [W-1:0]  in;
  logic          in_vld;
  logic [W-1:0]  out_r;
  logic          out_vld_r;
  logic          out_accept;
  logic [CW-1:0] credits_r;
  logic          err_r;

  modport master (
    output issue_vld, in, in_vld, out_accept,
    input  issue_ok, out_r, out_vld_r, credits_r, err_r
  );

  modport slave (
    input  issue_vld, in, in_vld, out_accept,
    output issue_ok, out_r, out_vld_r, credits_r, err_r
  );
endinterface

// File: rtl/delay_pipe_egress_fifo.sv
// Circular storage behind the head register; occupancy counter separates full from empty.
module delay_pipe_egress_fifo
  import delay_pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= PW'(ptr_wrap_inc(32'(r_wr_ptr), 32'(DEPTH - 1)));
      if (i_pop)  r_rd_ptr <= PW'(ptr_wrap_inc(32'(r_rd_ptr), 32'(DEPTH - 1)));
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  // Full-with-pop writes the slot being read this cycle; the read is combinational so it is safe.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/delay_pipe_egress_buffer.sv
// Egress buffer for the static delay pipe: head register with bypass, optional
// storage FIFO, credit counter gating issues, and a sticky protocol-error flag.
module delay_pipe_egress_buffer
  import delay_pipe_pkg::*;
#(
  parameter int D = 4,
  parameter int W = 32
) (
  input  logic clk,
  input  logic rst,
  delay_pipe_egress_buffer_if.slave bus
);
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  r_head;
  logic          r_head_vld;
  logic [CW-1:0] r_credits;
  logic          r_err;

  logic          w_issue;
  logic          w_pop;
  logic          w_head_load;
  logic          w_bypass;
  logic          w_fifo_push;
  logic          w_fifo_pop;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [W-1:0]  w_fifo_dout;
  err_cause_e    w_cause;

  assign bus.issue_ok  = rst && (r_credits != '0);
  assign bus.out_r     = r_head;
  assign bus.out_vld_r = r_head_vld;
  assign bus.credits_r = r_credits;
  assign bus.err_r     = r_err;

  assign w_issue     = bus.issue_vld && bus.issue_ok;
  assign w_pop       = r_head_vld && bus.out_accept;
  assign w_head_load = !r_head_vld || w_pop;
  assign w_bypass    = w_head_load && w_fifo_empty;
  assign w_fifo_pop  = w_head_load && !w_fifo_empty;
  assign w_fifo_push = bus.in_vld && !w_bypass && (!w_fifo_full || w_fifo_pop);

  always_comb begin
    w_cause = ERR_NONE;
    if (bus.issue_vld && !bus.issue_ok)
      w_cause = ERR_ISSUE;
    else if (bus.in_vld && !w_head_load && w_fifo_full)
      w_cause = ERR_OVERFLOW;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head_vld <= 1'b0;
      r_credits  <= CW'(D);
      r_err      <= 1'b0;
    end else begin
      if (w_head_load) r_head_vld <= !w_fifo_empty || bus.in_vld;
      if (w_issue && !w_pop)      r_credits <= r_credits - CW'(1);
      else if (!w_issue && w_pop) r_credits <= r_credits + CW'(1);
      if (w_cause != ERR_NONE) r_err <= 1'b1;
    end
  end

  // Head data is not reset and keeps its last value when the head empties.
  always_ff @(posedge clk) begin
    if (w_head_load) begin
      if (!w_fifo_empty)   r_head <= w_fifo_dout;
      else if (bus.in_vld) r_head <= bus.in;
    end
  end

  if (D > 1) begin : g_fifo
    delay_pipe_egress_fifo #(
      .DEPTH (D - 1),
      .W     (W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_fifo_push),
      .i_pop   (w_fifo_pop),
      .i_din   (bus.in),
      .o_dout  (w_fifo_dout),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
    );
  end else begin : g_no_fifo
    assign w_fifo_dout  = '0;
    assign w_fifo_empty = 1'b1;
    assign w_fifo_full  = 1'b1;
  end

endmodule
